axi_rd_responder: RTL and testbench

//  AXI4 read-channel subordinate (AR/R only) terminating the shared region at 0x4000_0000.

---
 rtl/axi_rd_responder.sv | 174 +++++++++++++++++
 tb/tb_axi_rd_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_responder.sv
// AXI4 read-only subordinate: queues AR commands and streams INCR/FIXED bursts
// from a preloadable word memory, with occupancy and AR stall counters.
module axi_rd_responder #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                ID_W      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h4000_0000,
  parameter int                MEM_WORDS = 1024,
  parameter int                AR_DEPTH  = 16,
  localparam int               MW_W      = $clog2(MEM_WORDS),
  localparam int               AD_W      = $clog2(AR_DEPTH),
  localparam int               OUT_W     = AD_W + 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [ID_W-1:0]   s_rid,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              s_rvalid,
  input  logic              s_rready,
  input  logic              mem_we,
  input  logic [MW_W-1:0]   mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [OUT_W-1:0]  outstanding,
  output logic [31:0]       ar_stall_cycles
);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic              fixed;
    logic              err;
  } cmd_t;

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [AD_W:0]   FIFO_FULL = (AD_W + 1)'(AR_DEPTH);
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(4 * MEM_WORDS);

  cmd_t              fifo_mem [AR_DEPTH];
  cmd_t              new_cmd;
  cmd_t              head;
  logic [AD_W-1:0]   wr_ptr;
  logic [AD_W-1:0]   rd_ptr;
  logic [AD_W:0]     fifo_count;
  logic              ready_en;
  logic              push;
  logic              pop;
  logic              fifo_empty;

  state_t            state;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        beats_left;
  logic [ID_W-1:0]   id_reg;
  logic              err_reg;
  logic              fixed_reg;
  logic              data_ok;
  logic              load_beat;
  logic              last_load;
  logic              r_done;
  logic [ADDR_W-1:0] offset;
  logic              beat_err;
  logic [MW_W-1:0]   mem_idx;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [DATA_W-1:0] mem_q;

  // arready stays low for the first cycle after reset release
  assign s_arready  = ready_en && (fifo_count < FIFO_FULL);
  assign push       = s_arvalid && s_arready;
  assign fifo_empty = (fifo_count == '0);
  assign head       = fifo_mem[rd_ptr];

  always_comb begin
    new_cmd       = '0;
    new_cmd.id    = s_arid;
    new_cmd.addr  = s_araddr;
    new_cmd.len   = s_arlen;
    new_cmd.fixed = (s_arburst == 2'b00);
    new_cmd.err   = (s_arsize != 3'b010) || s_arburst[1];
  end

  assign load_beat = (state == BURST) && (!s_rvalid || s_rready);
  assign last_load = load_beat && (beats_left == 8'd0);
  assign pop       = !fifo_empty && ((state == IDLE) || last_load);
  assign r_done    = s_rvalid && s_rready && s_rlast;

  // Addresses below BASE_ADDR wrap to a large offset and fail the range check
  assign offset    = addr_reg - BASE_ADDR;
  assign beat_err  = err_reg || (offset >= MEM_BYTES);
  assign mem_idx   = offset[MW_W+1:2];
  assign s_rdata   = data_ok ? mem_q : '0;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= new_cmd;
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (load_beat) mem_q <= mem[mem_idx];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      ready_en        <= 1'b0;
      addr_reg        <= '0;
      beats_left      <= '0;
      id_reg          <= '0;
      err_reg         <= 1'b0;
      fixed_reg       <= 1'b0;
      s_rvalid        <= 1'b0;
      s_rlast         <= 1'b0;
      s_rid           <= '0;
      s_rresp         <= 2'b00;
      data_ok         <= 1'b0;
      outstanding     <= '0;
      ar_stall_cycles <= '0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      case ({push, r_done})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (s_arvalid && !s_arready && (ar_stall_cycles != 32'hFFFF_FFFF))
        ar_stall_cycles <= ar_stall_cycles + 1'b1;

      if (load_beat) begin
        s_rvalid   <= 1'b1;
        s_rid      <= id_reg;
        s_rresp    <= beat_err ? 2'b10 : 2'b00;
        s_rlast    <= (beats_left == 8'd0);
        data_ok    <= !beat_err;
        beats_left <= beats_left - 1'b1;
        if (!fixed_reg) addr_reg <= addr_reg + ADDR_W'(4);
      end else if (s_rready) begin
        s_rvalid <= 1'b0;
      end

      // A pop on the last beat overrides the address/count advance above
      if (pop) begin
        addr_reg   <= head.addr;
        beats_left <= head.len;
        id_reg     <= head.id;
        err_reg    <= head.err;
        fixed_reg  <= head.fixed;
        state      <= BURST;
      end else if (last_load) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder: table-driven single bursts plus
// hand-written flood, back-to-back streaming and mid-burst reset sequences.
module tb_axi_rd_responder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  s_arid = '0;
  logic [31:0] s_araddr = '0;
  logic [7:0]  s_arlen = '0;
  logic [2:0]  s_arsize = 3'd2;
  logic [1:0]  s_arburst = 2'b01;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [3:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic        mem_we = 1'b0;
  logic [9:0]  mem_waddr = '0;
  logic [31:0] mem_wdata = '0;
  logic [5:0]  outstanding;
  logic [31:0] ar_stall_cycles;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  axi_rd_responder dut (
    .clock(clock), .reset_n(reset_n),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .outstanding(outstanding), .ar_stall_cycles(ar_stall_cycles)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] d0;     // data of beat 0 when OKAY
    logic [31:0] step;   // data increment per beat (0 for FIXED)
    int          ok;     // beats 0..ok-1 are OKAY, the rest SLVERR
    bit          rnd;    // random rready
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input int n, input vec_t v);
    logic [39:0] saved;
    logic [31:0] exp_data;
    bit          stalled = 0;
    bit          first_seen = 0;
    int          k = 0;
    s_arid = v.id; s_araddr = v.addr; s_arlen = v.len;
    s_arsize = v.size; s_arburst = v.burst; s_arvalid = 1'b1;
    for (int g = 0; g < 50 && !s_arready; g++) @(negedge clock);
    if (!s_arready) chk($sformatf("v%0d_arready_timeout", n), 0, 1);
    @(negedge clock);
    s_arvalid = 1'b0;
    for (int c = 0; c < 400 && k <= int'(v.len); c++) begin
      if (stalled)
        chk($sformatf("v%0d_hold", n), {s_rvalid, s_rid, s_rdata, s_rresp, s_rlast}, saved);
      s_rready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 0;
      if (s_rvalid) begin
        if (!first_seen) begin
          first_seen = 1;
          chk($sformatf("v%0d_latency", n), c, 2);
        end
        if (s_rready) begin
          exp_data = (k < v.ok) ? v.d0 + v.step * k : 32'h0;
          chk($sformatf("v%0d_beat%0d", n, k), {s_rid, s_rdata, s_rresp, s_rlast},
              {v.id, exp_data, (k < v.ok) ? 2'b00 : 2'b10, k == int'(v.len)});
          $display("v%0d beat %0d rid=%0d rdata=%h rresp=%0d rlast=%0d",
                   n, k, s_rid, s_rdata, s_rresp, s_rlast);
          k++;
        end else begin
          saved = {s_rvalid, s_rid, s_rdata, s_rresp, s_rlast};
          stalled = 1;
        end
      end
      @(negedge clock);
    end
    s_rready = 1'b0;
    chk($sformatf("v%0d_beats", n), k, int'(v.len) + 1);
    chk($sformatf("v%0d_outstanding_end", n), outstanding, 0);
    chk($sformatf("v%0d_rvalid_end", n), s_rvalid, 0);
  endtask

  initial begin
    int accepted, stalls, b, k, errs, bubbles;

    tbl[0] = '{4'd5, 32'h4000_0000, 8'd3,  3'd2, 2'b01, 32'hCAFE_0000, 32'd1, 4,  1'b0};
    tbl[1] = '{4'd1, 32'h4000_0FFC, 8'd1,  3'd2, 2'b01, 32'hCAFE_03FF, 32'd1, 1,  1'b0};
    tbl[2] = '{4'd2, 32'h4000_0000, 8'd2,  3'd3, 2'b01, 32'h0,         32'd0, 0,  1'b0};
    tbl[3] = '{4'd3, 32'h4000_0000, 8'd2,  3'd2, 2'b10, 32'h0,         32'd0, 0,  1'b0};
    tbl[4] = '{4'd4, 32'h4000_0010, 8'd3,  3'd2, 2'b00, 32'hCAFE_0004, 32'd0, 4,  1'b0};
    tbl[5] = '{4'd6, 32'h4000_0100, 8'd15, 3'd2, 2'b01, 32'hCAFE_0040, 32'd1, 16, 1'b1};
    tbl[6] = '{4'd7, 32'h3FFF_FF00, 8'd0,  3'd2, 2'b01, 32'h0,         32'd0, 0,  1'b0};
    tbl[7] = '{4'd8, 32'h5000_0000, 8'd1,  3'd2, 2'b00, 32'h0,         32'd0, 0,  1'b1};

    // Reset state
    #1 reset_n = 1'b0;
    #2;
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_rid_rresp_rlast", {s_rid, s_rresp, s_rlast}, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_stall", ar_stall_cycles, 0);
    repeat (3) @(negedge clock);
    chk("rst_arready", s_arready, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_arready", s_arready, 1);

    for (int i = 0; i < 1024; i++) begin
      mem_we = 1'b1; mem_waddr = 10'(i); mem_wdata = 32'hCAFE_0000 | i;
      @(negedge clock);
    end
    mem_we = 1'b0;

    for (int n = 0; n < 8; n++) run_cmd(n, tbl[n]);

    // Flood: 17 accepted (16 queued + 1 loaded); an 18th request is held
    // for 5 stalled cycles and then withdrawn.
    accepted = 0; stalls = 0;
    s_rready = 1'b0; s_araddr = 32'h4000_0000; s_arlen = 8'd255;
    s_arsize = 3'd2; s_arburst = 2'b01;
    for (int c = 0; c < 100 && (accepted < 17 || stalls < 5); c++) begin
      s_arvalid = 1'b1; s_arid = 4'(accepted);
      if (s_arready) accepted++; else stalls++;
      @(negedge clock);
    end
    s_arvalid = 1'b0;
    $display("flood accepted=%0d stalls=%0d outstanding=%0d stall_cnt=%0d",
             accepted, stalls, outstanding, ar_stall_cycles);
    chk("flood_accepted", accepted, 17);
    chk("flood_arready", s_arready, 0);
    chk("flood_outstanding", outstanding, 17);
    chk("flood_stall_cnt", ar_stall_cycles, 5);
    chk("flood_rvalid", s_rvalid, 1);

    b = 0; k = 0; errs = 0; bubbles = 0;
    s_rready = 1'b1;
    for (int c = 0; c < 5000 && b < 17; c++) begin
      if (s_rvalid) begin
        if ({s_rid, s_rdata, s_rresp, s_rlast} !== {4'(b), 32'hCAFE_0000 | k, 2'b00, k == 255}) begin
          if (errs < 4)
            $display("stream burst %0d beat %0d rid=%0d rdata=%h rresp=%0d rlast=%0d",
                     b, k, s_rid, s_rdata, s_rresp, s_rlast);
          errs++;
        end
        k++;
        if (k == 256) begin
          $display("stream burst %0d done rid=%0d", b, s_rid);
          k = 0; b++;
        end
      end else begin
        bubbles++;
      end
      @(negedge clock);
    end
    s_rready = 1'b0;
    chk("stream_bursts", b, 17);
    chk("stream_beat_errors", errs, 0);
    chk("stream_bubbles", bubbles, 0);
    chk("stream_outstanding", outstanding, 0);

    // Reset in the middle of a burst
    s_arid = 4'd9; s_araddr = 32'h4000_0000; s_arlen = 8'd15;
    s_arsize = 3'd2; s_arburst = 2'b01; s_arvalid = 1'b1;
    @(negedge clock);
    s_arvalid = 1'b0; s_rready = 1'b1;
    repeat (5) @(negedge clock);
    chk("midrst_pre_rvalid", s_rvalid, 1);
    #2 reset_n = 1'b0;
    #1;
    $display("midrst rvalid=%0d outstanding=%0d", s_rvalid, outstanding);
    chk("midrst_rvalid", s_rvalid, 0);
    chk("midrst_outstanding", outstanding, 0);
    chk("midrst_rlast_rdata", {s_rlast, s_rdata}, 0);
    @(negedge clock);
    chk("midrst_arready", s_arready, 0);
    reset_n = 1'b1;
    s_rready = 1'b0;
    @(negedge clock);
    chk("midrst_post_arready", s_arready, 1);
    chk("midrst_post_rvalid", s_rvalid, 0);
    run_cmd(8, tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
